transpose_stream_5: RTL and testbench
=====================================

// Module: transpose_stream_5
// PURPOSE
//  Streaming bit-matrix corner-turn buffer for the router's serialized request/grant links.
//  Accepts an NxN bit matrix one row per beat and returns its transpose one column per beat.
//  Column k bit i equals row i bit k, so this is the sequential counterpart of the router's
//  combinational transpose.
//  Ping-pong double buffer with valid/ready on both sides:
//  - one matrix fills while the other drains;
//  - sustained throughput is 1 beat/cycle.
// PARAMETERS
//  N   5   matrix dimension: row/column width and beats per matrix (N >= 2)
// PORTS
//  clk          in   1        single clock, rising edge
//  rstn         in   1        asynchronous active-low reset
//  flush        in   1        sync clear of both banks and all counters, higher priority than handshakes
//  in_valid     in   1        in_row valid
//  in_ready     out  1        buffer can accept a row
//  in_row       in   N        row data, row index implied by arrival order
//  out_valid    out  1        out_col valid
//  out_ready    in   1        consumer accepts column
//  out_col      out  N        column data: out_col[i] = row_i[out_idx]
//  out_idx      out  clog2(N) index of current column
//  out_last     out  1        high with the final column (out_idx == N-1)
// BEHAVIOUR
//  Reset (async, rstn=0):
//  - both banks empty, all storage = 0, wr_bank = rd_bank = 0, wr_cnt = rd_cnt = 0;
//  - outputs: in_ready=1, out_valid=0, out_col=0, out_idx=0, out_last=0.
//  State:
//  - bank[b] is an NxN register array with a full[b] flag;
//  - pointers wr_bank and rd_bank, counters wr_cnt and rd_cnt, range 0..N-1.
//  Input side:
//  - in_ready = !full[wr_bank];
//  - on accept (in_valid & in_ready), bank[wr_bank].row[wr_cnt] <= in_row and wr_cnt++;
//  - on the accept where wr_cnt == N-1: full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
//  Output side:
//  - out_valid = full[rd_bank];
//  - out_col, out_idx and out_last are combinational from registered state;
//    they are 0 when out_valid = 0;
//  - on accept (out_valid & out_ready), rd_cnt++;
//  - on the accept where rd_cnt == N-1: full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0.
//  - out_col and out_idx hold stable while out_valid & !out_ready.
//  Latency:
//  - the last row of a matrix is accepted in cycle t; column 0 is valid in cycle t+1;
//  - no combinational path from in_valid to out_valid, or from out_ready to in_ready.
//  Simultaneous events:
//  - a fill-complete and a drain-complete in the same cycle target different banks;
//    both take effect;
//  - the freed bank is writable the next cycle.
//  Full:
//  - both banks full -> in_ready = 0 until the drain-complete of the oldest matrix;
//  - in_ready is 1 in the cycle after that drain-complete.
//  Empty:
//  - no full bank -> out_valid = 0;
//  - a partial matrix is never emitted.
//  flush = 1:
//  - next state equals the reset state;
//  - handshakes in that cycle are discarded; accepted partial rows are lost.
//  Reset mid-fill or mid-drain: all data is discarded, no beat is emitted after rstn rises.
//  Counters wrap only through the N-1 terminal rule; no out-of-range index is ever produced.
// TESTING
//  - Identity: rows 00001,00010,00100,01000,10000 with out_ready=1
//    -> columns 00001..10000 in order, out_last on beat 4, out_valid 1 cycle after row 4.
//  - Pattern: rows 11111,00000,11111,00000,11111
//    -> five columns, each 10101, out_idx 0..4.
//  - Backpressure: out_ready=0 while in_valid=1 continuously
//    -> exactly 10 rows accepted, in_ready=0 from then on;
//    -> raise out_ready: in_ready returns 1 the cycle after the 5th column.
//  - Streaming: 4 back-to-back matrices, in_valid=out_ready=1
//    -> no bubbles after the first 5-cycle fill, every column correct.
//  - Flush: 3 rows in, flush=1 for 1 cycle
//    -> out_valid stays 0; the next 5 rows are emitted as matrix 0 with out_idx starting at 0.
//  - Async reset mid-drain after column 2: rstn=0
//    -> out_valid=0 and in_ready=1 immediately; no further columns.

Source files
------------

// File: rtl/transpose_stream_5_if.sv
`default_nettype none
// ============================================================================
// Module   : transpose_stream_5_if
// Function : Row-in / column-out valid-ready bundle for transpose_stream_5.
// Revision : 1.0
// ============================================================================
interface transpose_stream_5_if #(
    parameter int N = 5
);
    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;

    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_row;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_col;
    logic [c_idx_w-1:0] out_idx;
    logic               out_last;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_col, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_col, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/transpose_stream_5.sv
`default_nettype none
// ============================================================================
// Module   : transpose_stream_5
// Function : Ping-pong NxN bit-matrix corner turn, one row in / one column out per beat.
// Revision : 1.0
// ============================================================================
module transpose_stream_5 #(
    parameter int N = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    transpose_stream_5_if.slave  bus
);
    localparam int                 c_idx_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(N - 1);

    logic [N-1:0]       r_bank [2][N];
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [c_idx_w-1:0] r_wr_cnt;
    logic [c_idx_w-1:0] r_rd_cnt;

    logic               w_in_acc;
    logic               w_out_acc;
    logic               w_out_valid;
    logic [N-1:0]       w_col;

    assign w_out_valid = r_full[r_rd_bank];
    assign w_in_acc    = bus.in_valid & ~r_full[r_wr_bank];
    assign w_out_acc   = w_out_valid & bus.out_ready;

    // Column k of the draining bank: bit i is row i, bit k.
    always_comb begin
        w_col = '0;
        for (int i = 0; i < N; i++) begin
            w_col[i] = r_bank[r_rd_bank][i][r_rd_cnt];
        end
    end

    assign bus.in_ready  = ~r_full[r_wr_bank];
    assign bus.out_valid = w_out_valid;
    assign bus.out_col   = w_out_valid ? w_col : '0;
    assign bus.out_idx   = w_out_valid ? r_rd_cnt : '0;
    assign bus.out_last  = w_out_valid & (r_rd_cnt == c_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < N; r++) begin
                    r_bank[b][r] <= '0;
                end
            end
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else if (flush) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < N; r++) begin
                    r_bank[b][r] <= '0;
                end
            end
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            // Fill and drain always target different banks, so both may complete together.
            if (w_in_acc) begin
                r_bank[r_wr_bank][r_wr_cnt] <= bus.in_row;
                if (r_wr_cnt == c_last) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_cnt          <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_out_acc) begin
                if (r_rd_cnt == c_last) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                    r_rd_cnt          <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_transpose_stream_5.sv
`default_nettype none
// ============================================================================
// Module   : tb_transpose_stream_5
// Function : Scoreboard bench for transpose_stream_5 with directed matrices.
// Revision : 1.0
// ============================================================================
module tb_transpose_stream_5;
    localparam int N  = 5;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   total_beats = 0;
    int   last_beat_cyc = 0;

    logic [N+IW:0] exp_q [$];

    transpose_stream_5_if #(.N(N)) bus ();

    transpose_stream_5 #(.N(N)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] id_rows  [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    logic [N-1:0] pat_rows [5] = '{5'b11111, 5'b00000, 5'b11111, 5'b00000, 5'b11111};
    logic [N-1:0] bp_rows  [10] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001,
                                    5'b00111, 5'b00011, 5'b00001, 5'b00000, 5'b11111};
    logic [N-1:0] bp_cols  [10] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001,
                                    5'b10111, 5'b10011, 5'b10001, 5'b10000, 5'b10000};
    logic [N-1:0] fl_rows  [5] = '{5'b11000, 5'b01100, 5'b00110, 5'b00011, 5'b10001};
    logic [N-1:0] fl_cols  [5] = '{5'b11000, 5'b01100, 5'b00110, 5'b00011, 5'b10001};

    function automatic logic [N-1:0] col_of(input logic [N-1:0][N-1:0] m, input int k);
        logic [N-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c[i] = m[i][k];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push_col(input logic [N-1:0] col, input int k);
        exp_q.push_back({col, IW'(k), (k == N - 1)});
    endtask

    task automatic send_row(input logic [N-1:0] row);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("send_row_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted column is checked against the head of the scoreboard.
    initial begin
        logic [N+IW:0] e;
        logic [N+IW:0] got;
        forever begin
            @(negedge clk);
            if (rstn && !flush) begin
                got = {bus.out_col, bus.out_idx, bus.out_last};
                if (bus.out_valid && bus.out_ready) begin
                    total_beats++;
                    last_beat_cyc = cyc;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_beat got col=%b idx=%0d last=%b want none",
                                 bus.out_col, bus.out_idx, bus.out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            fails++;
                            $display("FAIL column_beat got col=%b idx=%0d last=%b want col=%b idx=%0d last=%b",
                                     got[N+IW:IW+1], got[IW:1], got[0], e[N+IW:IW+1], e[IW:1], e[0]);
                        end
                    end
                end else if (!bus.out_valid) begin
                    tests++;
                    if (got !== '0) begin
                        fails++;
                        $display("FAIL idle_outputs got=%b want=0", got);
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0][N-1:0] m;
        int acc;
        int c0;
        int b0;

        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #12;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_col",   32'(bus.out_col),   32'd0);
        check("rst_out_idx",   32'(bus.out_idx),   32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Identity matrix with one-cycle latency check
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) push_col(id_rows[k], k);
        for (int r = 0; r < N - 1; r++) send_row(id_rows[r]);
        bus.in_valid = 1'b1;
        bus.in_row   = id_rows[N-1];
        @(negedge clk);
        check("id_last_row_ready", 32'(bus.in_ready),  32'd1);
        check("id_no_early_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("id_latency_valid", 32'(bus.out_valid), 32'd1);
        wait_drain("identity");

        // Alternating full/empty rows
        for (int k = 0; k < N; k++) push_col(5'b10101, k);
        for (int r = 0; r < N; r++) send_row(pat_rows[r]);
        wait_drain("pattern");

        // Backpressure: both banks fill, then drain releases the first bank
        bus.out_ready = 1'b0;
        for (int j = 0; j < 10; j++) push_col(bp_cols[j], j % N);
        acc = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.in_row = (acc < 10) ? bp_rows[acc] : '0;
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("bp_rows_accepted", 32'(acc),            32'd10);
        check("bp_in_ready_low",  32'(bus.in_ready),   32'd0);
        check("bp_hold_col",      32'(bus.out_col),    32'(bp_cols[0]));
        check("bp_hold_idx",      32'(bus.out_idx),    32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) @(negedge clk);
        check("bp_ready_during_last_col", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("bp_ready_after_drain", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        wait_drain("backpressure");

        // Streaming: four back-to-back matrices
        b0 = total_beats;
        c0 = cyc;
        for (int mt = 0; mt < 4; mt++) begin
            for (int r = 0; r < N; r++) m[r] = 5'(mt * 11 + r * 7 + 3);
            for (int k = 0; k < N; k++) push_col(col_of(m, k), k);
            for (int r = 0; r < N; r++) send_row(m[r]);
        end
        check("stream_input_cycles", 32'(cyc - c0), 32'd20);
        wait_drain("stream");
        check("stream_beats",     32'(total_beats - b0),   32'd20);
        check("stream_last_beat", 32'(last_beat_cyc - c0), 32'd24);

        // Flush discards a partial matrix
        for (int r = 0; r < 3; r++) send_row(5'b11111);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready",  32'(bus.in_ready),  32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("flush_still_empty", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < N; k++) push_col(fl_cols[k], k);
        for (int r = 0; r < N; r++) send_row(fl_rows[r]);
        wait_drain("flush");

        // Asynchronous reset in the middle of a drain
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) push_col(id_rows[k], k);
        for (int r = 0; r < N; r++) send_row(id_rows[r]);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        check("arst_cols_seen", 32'(exp_q.size()),  32'd2);
        exp_q.delete();
        b0 = total_beats;
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("arst_no_beats", 32'(total_beats - b0), 32'd0);
        check("arst_idle",     32'(bus.out_valid),    32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
